reg_bank_fwd: RTL and testbench

- Parametrised successor of the 16-bit register bank: NUM_REGS x DATA_W register file with one write port and two read ports (A, B).
- Each read port has a forwarding mux over the EX, DM and WB results. Port B also has an immediate override.
- Forwarding is either steered externally or resolved internally by destination-tag compare, selected by a parameter.
- Sits in the decode stage. Outputs are registered and form the ID/EX operand latch.

---
 rtl/reg_bank_fwd_pkg.sv | 17 +
 rtl/reg_bank_fwd_fwd_resolve.sv | 36 +++
 rtl/reg_bank_fwd.sv | 136 +++++++++++++
 tb/tb_reg_bank_fwd.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_fwd_pkg.sv
// Shared types and default sizes for the forwarding register bank.
//   fwd_sel_t    : operand source code, also driven out on fwd_a / fwd_b
//   DEF_DATA_W   : default operand width
//   DEF_NUM_REGS : default number of architectural registers
package reg_bank_fwd_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 32;

   typedef enum logic [1:0] {
      SRC_RF = 2'b00,
      SRC_EX = 2'b01,
      SRC_DM = 2'b10,
      SRC_WB = 2'b11
   } fwd_sel_t;

endpackage

// File: rtl/reg_bank_fwd_fwd_resolve.sv
// Forwarding source resolution for one read port by destination-tag compare.
//   rx                  : source register index of the port
//   rd_ex, rd_dm, rd_wb : destination tags of the in-flight results
//   vld_ex, vld_dm, vld_wb : tag valid flags
//   sel                 : chosen source; youngest matching producer wins
module fwd_resolve
   import reg_bank_fwd_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [ADDR_W-1:0] rx,
   input  logic [ADDR_W-1:0] rd_ex,
   input  logic [ADDR_W-1:0] rd_dm,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic              vld_ex,
   input  logic              vld_dm,
   input  logic              vld_wb,
   output fwd_sel_t          sel
);

   // The hardwired zero register must never pick up a forwarded value,
   // even if some stage claims it as a destination.
   always_comb begin
      sel = SRC_RF;
      if (ZERO_REG && (rx == '0))
         sel = SRC_RF;
      else if (vld_ex && (rd_ex == rx))
         sel = SRC_EX;
      else if (vld_dm && (rd_dm == rx))
         sel = SRC_DM;
      else if (vld_wb && (rd_wb == rx))
         sel = SRC_WB;
   end

endmodule

// File: rtl/reg_bank_fwd.sv
// Decode-stage register bank with operand forwarding; outputs form the
// ID/EX operand latch.
//   clk, rst_n          : clock, synchronous active-low reset
//   ra, rb              : source register indices
//   ans_ex/dm/wb        : stage results (ans_wb is also the write data)
//   rd_ex/dm/wb, vld_*  : destination tags and their valid flags
//   mux_sel_a/b         : external source select (AUTO_FWD=0 only)
//   imm, imm_sel        : immediate operand, overrides port B when set
//   hold                : stall; operand latch keeps its value
//   a, b, fwd_a, fwd_b  : registered operands and the source code chosen
module reg_bank_fwd
   import reg_bank_fwd_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter bit AUTO_FWD = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] ans_dm,
   input  logic [DATA_W-1:0] ans_wb,
   input  logic [ADDR_W-1:0] rd_ex,
   input  logic [ADDR_W-1:0] rd_dm,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic              vld_ex,
   input  logic              vld_dm,
   input  logic              vld_wb,
   input  logic [1:0]        mux_sel_a,
   input  logic [1:0]        mux_sel_b,
   input  logic [DATA_W-1:0] imm,
   input  logic              imm_sel,
   input  logic              hold,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rf_a, rf_b;
   logic [DATA_W-1:0] val_a, val_b;
   fwd_sel_t          sel_a, sel_b;
   logic              wr_en;

   // Depending on AUTO_FWD, either the tags or the external selects are
   // ignored; fold them here so the unused half does not dangle.
   logic unused_inputs;
   assign unused_inputs = ^{mux_sel_a, mux_sel_b, rd_ex, rd_dm, vld_ex, vld_dm};

   assign wr_en = vld_wb && !(ZERO_REG && (rd_wb == '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[rd_wb] <= ans_wb;
      end
   end

   // Array read happens before the write lands, so a same-cycle read of
   // the written register sees the old value unless the WB bypass is chosen.
   assign rf_a = (ZERO_REG && (ra == '0)) ? '0 : regs[ra];
   assign rf_b = (ZERO_REG && (rb == '0)) ? '0 : regs[rb];

   if (AUTO_FWD) begin : g_auto
      fwd_resolve #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_res_a (
         .rx     (ra),
         .rd_ex  (rd_ex),
         .rd_dm  (rd_dm),
         .rd_wb  (rd_wb),
         .vld_ex (vld_ex),
         .vld_dm (vld_dm),
         .vld_wb (vld_wb),
         .sel    (sel_a)
      );
      fwd_resolve #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_res_b (
         .rx     (rb),
         .rd_ex  (rd_ex),
         .rd_dm  (rd_dm),
         .rd_wb  (rd_wb),
         .vld_ex (vld_ex),
         .vld_dm (vld_dm),
         .vld_wb (vld_wb),
         .sel    (sel_b)
      );
   end else begin : g_manual
      assign sel_a = fwd_sel_t'(mux_sel_a);
      assign sel_b = fwd_sel_t'(mux_sel_b);
   end

   always_comb begin
      val_a = rf_a;
      case (sel_a)
         SRC_EX:  val_a = ans_ex;
         SRC_DM:  val_a = ans_dm;
         SRC_WB:  val_a = ans_wb;
         default: val_a = rf_a;
      endcase
   end

   always_comb begin
      val_b = rf_b;
      case (sel_b)
         SRC_EX:  val_b = ans_ex;
         SRC_DM:  val_b = ans_dm;
         SRC_WB:  val_b = ans_wb;
         default: val_b = rf_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a     <= '0;
         b     <= '0;
         fwd_a <= SRC_RF;
         fwd_b <= SRC_RF;
      end else if (!hold) begin
         a     <= val_a;
         fwd_a <= sel_a;
         if (imm_sel) begin
            b     <= imm;
            fwd_b <= SRC_RF;
         end else begin
            b     <= val_b;
            fwd_b <= sel_b;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_fwd.sv
// Testbench for reg_bank_fwd: directed vector table, hand sequences for the
// manual-select and wide builds, then random stimulus against a model.
module tb_reg_bank_fwd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus for the auto (dut) and manual (dut_m) instances
   logic        rst_n, hold, imm_sel;
   logic [4:0]  ra, rb, rd_ex, rd_dm, rd_wb;
   logic        vld_ex, vld_dm, vld_wb;
   logic [15:0] ans_ex, ans_dm, ans_wb, imm;
   logic [1:0]  mux_sel_a, mux_sel_b;
   logic [15:0] a, b, am, bm;
   logic [1:0]  fwd_a, fwd_b, fam, fbm;

   // wide build: DATA_W=32, NUM_REGS=16
   logic        w_rst_n, w_hold, w_imm_sel;
   logic [3:0]  w_ra, w_rb, w_rd_ex, w_rd_dm, w_rd_wb;
   logic        w_vld_ex, w_vld_dm, w_vld_wb;
   logic [31:0] w_ans_ex, w_ans_dm, w_ans_wb, w_imm;
   logic [1:0]  w_msa, w_msb;
   logic [31:0] w_a, w_b;
   logic [1:0]  w_fa, w_fb;

   reg_bank_fwd dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb),
      .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
      .rd_ex(rd_ex), .rd_dm(rd_dm), .rd_wb(rd_wb),
      .vld_ex(vld_ex), .vld_dm(vld_dm), .vld_wb(vld_wb),
      .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
      .imm(imm), .imm_sel(imm_sel), .hold(hold),
      .a(a), .b(b), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   reg_bank_fwd #(.AUTO_FWD(1'b0)) dut_m (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb),
      .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
      .rd_ex(rd_ex), .rd_dm(rd_dm), .rd_wb(rd_wb),
      .vld_ex(vld_ex), .vld_dm(vld_dm), .vld_wb(vld_wb),
      .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
      .imm(imm), .imm_sel(imm_sel), .hold(hold),
      .a(am), .b(bm), .fwd_a(fam), .fwd_b(fbm)
   );

   reg_bank_fwd #(.DATA_W(32), .NUM_REGS(16)) dut_w (
      .clk(clk), .rst_n(w_rst_n), .ra(w_ra), .rb(w_rb),
      .ans_ex(w_ans_ex), .ans_dm(w_ans_dm), .ans_wb(w_ans_wb),
      .rd_ex(w_rd_ex), .rd_dm(w_rd_dm), .rd_wb(w_rd_wb),
      .vld_ex(w_vld_ex), .vld_dm(w_vld_dm), .vld_wb(w_vld_wb),
      .mux_sel_a(w_msa), .mux_sel_b(w_msb),
      .imm(w_imm), .imm_sel(w_imm_sel), .hold(w_hold),
      .a(w_a), .b(w_b), .fwd_a(w_fa), .fwd_b(w_fb)
   );

   typedef struct {
      logic        rst_n, hold, imm_sel;
      logic [4:0]  ra, rb, rd_ex, rd_dm, rd_wb;
      logic        vld_ex, vld_dm, vld_wb;
      logic [15:0] ans_ex, ans_dm, ans_wb, imm;
      logic [15:0] ea, eb;
      logic [1:0]  efa, efb;
   } vec_t;

   vec_t tbl[$];
   int   nerr = 0;
   int   nchk = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s #%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t idle();
      vec_t v;
      v.rst_n = 1'b1; v.hold = 1'b0; v.imm_sel = 1'b0;
      v.ra = '0; v.rb = '0; v.rd_ex = '0; v.rd_dm = '0; v.rd_wb = '0;
      v.vld_ex = 1'b0; v.vld_dm = 1'b0; v.vld_wb = 1'b0;
      v.ans_ex = '0; v.ans_dm = '0; v.ans_wb = '0; v.imm = '0;
      v.ea = '0; v.eb = '0; v.efa = '0; v.efb = '0;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      rst_n = v.rst_n; hold = v.hold; imm_sel = v.imm_sel; imm = v.imm;
      ra = v.ra; rb = v.rb; rd_ex = v.rd_ex; rd_dm = v.rd_dm; rd_wb = v.rd_wb;
      vld_ex = v.vld_ex; vld_dm = v.vld_dm; vld_wb = v.vld_wb;
      ans_ex = v.ans_ex; ans_dm = v.ans_dm; ans_wb = v.ans_wb;
      mux_sel_a = 2'b00; mux_sel_b = 2'b00;
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] m_regs [32];
   logic [15:0] e_a, e_b, e_am, e_bm;
   logic [1:0]  e_fa, e_fb, e_fam, e_fbm;

   function automatic void auto_src(input logic [4:0] x, output logic [15:0] v, output logic [1:0] c);
      if (x == 0)                       begin v = 16'h0;     c = 2'd0; end
      else if (vld_ex && rd_ex == x)    begin v = ans_ex;    c = 2'd1; end
      else if (vld_dm && rd_dm == x)    begin v = ans_dm;    c = 2'd2; end
      else if (vld_wb && rd_wb == x)    begin v = ans_wb;    c = 2'd3; end
      else                              begin v = m_regs[x]; c = 2'd0; end
   endfunction

   function automatic void man_src(input logic [4:0] x, input logic [1:0] s, output logic [15:0] v, output logic [1:0] c);
      c = s;
      case (s)
         2'd1:    v = ans_ex;
         2'd2:    v = ans_dm;
         2'd3:    v = ans_wb;
         default: v = (x == 0) ? 16'h0 : m_regs[x];
      endcase
   endfunction

   task automatic model_step();
      logic [15:0] na, nb, nam, nbm;
      logic [1:0]  nfa, nfb, nfam, nfbm;
      auto_src(ra, na, nfa);
      auto_src(rb, nb, nfb);
      man_src(ra, mux_sel_a, nam, nfam);
      man_src(rb, mux_sel_b, nbm, nfbm);
      if (imm_sel) begin nb = imm; nfb = 2'd0; nbm = imm; nfbm = 2'd0; end
      if (!rst_n) begin
         e_a = '0; e_b = '0; e_fa = '0; e_fb = '0;
         e_am = '0; e_bm = '0; e_fam = '0; e_fbm = '0;
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
      end else begin
         if (!hold) begin
            e_a = na; e_b = nb; e_fa = nfa; e_fb = nfb;
            e_am = nam; e_bm = nbm; e_fam = nfam; e_fbm = nfbm;
         end
         if (vld_wb && rd_wb != 0) m_regs[rd_wb] = ans_wb;
      end
   endtask

   initial begin
      vec_t v;

      w_rst_n = 1'b0; w_hold = 1'b0; w_imm_sel = 1'b0; w_imm = '0;
      w_ra = '0; w_rb = '0; w_rd_ex = '0; w_rd_dm = '0; w_rd_wb = '0;
      w_vld_ex = 1'b0; w_vld_dm = 1'b0; w_vld_wb = 1'b0;
      w_ans_ex = '0; w_ans_dm = '0; w_ans_wb = '0; w_msa = '0; w_msb = '0;

      // ---------------- directed vector table (auto instance) ----------------
      v = idle(); v.rst_n = 0; v.ra = 5; v.rb = 6; tbl.push_back(v);
      tbl.push_back(v);
      v = idle(); v.ra = 5; v.rb = 6; tbl.push_back(v);
      v = idle(); v.vld_wb = 1; v.rd_wb = 7; v.ans_wb = 16'hE000; v.ra = 7; v.rb = 6;
      v.ea = 16'hE000; v.efa = 3; tbl.push_back(v);
      v = idle(); v.ra = 7; v.ea = 16'hE000; tbl.push_back(v);
      v = idle(); v.ra = 9; v.rb = 9; v.vld_ex = 1; v.vld_dm = 1; v.vld_wb = 1;
      v.rd_ex = 9; v.rd_dm = 9; v.rd_wb = 9;
      v.ans_ex = 16'hC000; v.ans_dm = 16'hD000; v.ans_wb = 16'hE000;
      v.ea = 16'hC000; v.eb = 16'hC000; v.efa = 1; v.efb = 1; tbl.push_back(v);
      v.vld_ex = 0; v.ea = 16'hD000; v.eb = 16'hD000; v.efa = 2; v.efb = 2; tbl.push_back(v);
      v = idle(); v.imm_sel = 1; v.imm = 16'hFFFF; v.ra = 9; v.rb = 9;
      v.vld_ex = 1; v.rd_ex = 9; v.ans_ex = 16'hC000;
      v.ea = 16'hC000; v.efa = 1; v.eb = 16'hFFFF; v.efb = 0; tbl.push_back(v);
      v = idle(); v.vld_wb = 1; v.rd_wb = 0; v.ans_wb = 16'h1234; v.ra = 0; v.rb = 9;
      v.eb = 16'hE000; tbl.push_back(v);
      v = idle(); v.vld_ex = 1; v.rd_ex = 0; v.ans_ex = 16'h5555; v.ra = 0; v.rb = 7;
      v.eb = 16'hE000; tbl.push_back(v);
      v = idle(); v.vld_ex = 1; v.rd_ex = 3; v.ans_ex = 16'hC000; v.ra = 3; v.rb = 0;
      v.ea = 16'hC000; v.efa = 1; tbl.push_back(v);
      v.hold = 1; v.ans_ex = 16'hAAAA; v.rb = 5;
      for (int i = 0; i < 3; i++) tbl.push_back(v);
      v = idle(); v.hold = 1; v.rst_n = 0; v.ra = 3; tbl.push_back(v);
      v = idle(); v.ra = 7; v.rb = 9; tbl.push_back(v);
      v = idle(); v.vld_wb = 1; v.rd_wb = 31; v.ans_wb = 16'h8001; v.ra = 1; v.rb = 30; tbl.push_back(v);
      v = idle(); v.ra = 31; v.rb = 31; v.ea = 16'h8001; v.eb = 16'h8001; tbl.push_back(v);
      v = idle(); v.hold = 1; v.vld_wb = 1; v.rd_wb = 4; v.ans_wb = 16'h4444; v.ra = 4;
      v.ea = 16'h8001; v.eb = 16'h8001; tbl.push_back(v);
      v = idle(); v.ra = 4; v.rb = 31; v.ea = 16'h4444; v.eb = 16'h8001; tbl.push_back(v);
      v = idle(); v.ra = 4; v.rb = 31; v.vld_dm = 1; v.rd_dm = 4; v.ans_dm = 16'h0BEE;
      v.vld_wb = 1; v.rd_wb = 4; v.ans_wb = 16'h0FFF;
      v.ea = 16'h0BEE; v.efa = 2; v.eb = 16'h8001; tbl.push_back(v);

      foreach (tbl[i]) begin
         apply(tbl[i]);
         tick();
         chk("tbl_a", i, 32'(a), 32'(tbl[i].ea));
         chk("tbl_b", i, 32'(b), 32'(tbl[i].eb));
         chk("tbl_fwd_a", i, 32'(fwd_a), 32'(tbl[i].efa));
         chk("tbl_fwd_b", i, 32'(fwd_b), 32'(tbl[i].efb));
      end

      // ---------------- manual-select instance ----------------
      apply(idle()); ans_ex = 16'hC000; ans_dm = 16'hD000;
      mux_sel_a = 2'b10; mux_sel_b = 2'b01; ra = 3; rb = 4;
      tick();
      chk("man_a_dm", 0, 32'(am), 32'hD000);
      chk("man_b_ex", 0, 32'(bm), 32'hC000);
      chk("man_fwd_a", 0, 32'(fam), 32'd2);
      chk("man_fwd_b", 0, 32'(fbm), 32'd1);

      apply(idle()); vld_wb = 1; rd_wb = 12; ans_wb = 16'h1111; ra = 12; rb = 12;
      mux_sel_a = 2'b00; mux_sel_b = 2'b11;
      tick();
      chk("man_same_cyc_old", 1, 32'(am), 32'h0000);
      chk("man_same_cyc_wb", 1, 32'(bm), 32'h1111);
      chk("man_fwd_b_wb", 1, 32'(fbm), 32'd3);
      chk("auto_same_cyc_bypass", 1, 32'(a), 32'h1111);
      chk("auto_fwd_a_wb", 1, 32'(fwd_a), 32'd3);

      apply(idle()); ra = 12; rb = 0; ans_wb = 16'h7777; mux_sel_b = 2'b11;
      tick();
      chk("man_read_back", 2, 32'(am), 32'h1111);
      chk("man_r0_sel_wb", 2, 32'(bm), 32'h7777);

      apply(idle()); ra = 0; rb = 12; mux_sel_b = 2'b01; ans_ex = 16'h3333;
      imm_sel = 1; imm = 16'h9ABC;
      tick();
      chk("man_r0_zero", 3, 32'(am), 32'h0000);
      chk("man_imm", 3, 32'(bm), 32'h9ABC);
      chk("man_imm_fwd_b", 3, 32'(fbm), 32'd0);

      // ---------------- wide build ----------------
      tick();
      w_rst_n = 1'b1; w_vld_wb = 1; w_rd_wb = 15; w_ans_wb = 32'hDEADBEEF; w_ra = 15; w_rb = 14;
      tick();
      chk("wide_bypass", 0, w_a, 32'hDEADBEEF);
      chk("wide_bypass_fwd", 0, 32'(w_fa), 32'd3);
      chk("wide_r14", 0, w_b, 32'h0);
      w_vld_wb = 0; w_ans_wb = 32'h0;
      tick();
      chk("wide_read_r15", 1, w_a, 32'hDEADBEEF);
      chk("wide_read_fwd", 1, 32'(w_fa), 32'd0);

      // ---------------- randomized against the model ----------------
      for (int n = 0; n < 3000; n++) begin
         rst_n     = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         hold      = ($urandom_range(0, 5) == 0);
         imm_sel   = ($urandom_range(0, 7) == 0);
         imm       = 16'($urandom);
         ra        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rb        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rd_ex     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rd_dm     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rd_wb     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         vld_ex    = 1'($urandom);
         vld_dm    = 1'($urandom);
         vld_wb    = 1'($urandom);
         ans_ex    = 16'($urandom);
         ans_dm    = 16'($urandom);
         ans_wb    = 16'($urandom);
         mux_sel_a = 2'($urandom);
         mux_sel_b = 2'($urandom);
         model_step();
         tick();
         chk("rnd_a", n, 32'(a), 32'(e_a));
         chk("rnd_b", n, 32'(b), 32'(e_b));
         chk("rnd_fwd_a", n, 32'(fwd_a), 32'(e_fa));
         chk("rnd_fwd_b", n, 32'(fwd_b), 32'(e_fb));
         chk("rnd_man_a", n, 32'(am), 32'(e_am));
         chk("rnd_man_b", n, 32'(bm), 32'(e_bm));
         chk("rnd_man_fwd_a", n, 32'(fam), 32'(e_fam));
         chk("rnd_man_fwd_b", n, 32'(fbm), 32'(e_fbm));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
